tc_timer: RTL and testbench

TC_TIMER -- requirements
Module: tc_timer

---
 rtl/tc_timer.sv | 181 ++++++++++++++++++
 tb/tb_tc_timer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tc_timer
//  Description : 32-bit down-counting timer with one-shot / auto-reload modes,
//                a maskable interrupt flag and a 4-word register file
//                (CTRL, PRESET, COUNT, reserved).
//                Optional macro TC_PRESCALE_EN adds an 8-bit prescaler in
//                CTRL[15:8]; a count tick then occurs every PS+1 CNT cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tc_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [1:0] c_ADDR_CTRL   = 2'd0;
    localparam logic [1:0] c_ADDR_PRESET = 2'd1;
    localparam logic [1:0] c_ADDR_COUNT  = 2'd2;
    localparam logic [1:0] c_MODE_RELOAD = 2'd1;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_en;
    logic [1:0]  r_mode;
    logic        r_im;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_irq_flag;

    logic        w_ctrl_wr;
    logic        w_preset_wr;
    logic        w_tick;
    logic        w_count_done;
    logic        w_irq_set;
    logic        w_auto_reload;

    assign w_ctrl_wr     = WE && (Addr == c_ADDR_CTRL);
    assign w_preset_wr   = WE && (Addr == c_ADDR_PRESET);
    // COUNT of 0 and 1 both terminate, so PRESET=0 acts like PRESET=1
    // and the counter can never wrap.
    assign w_count_done  = (r_count <= 32'd1);
    // Modes 2 and 3 fall back to one-shot behaviour.
    assign w_auto_reload = (r_mode == c_MODE_RELOAD);
    assign w_irq_set     = (r_state == S_CNT) && (w_state_nxt == S_INT);

`ifdef TC_PRESCALE_EN
    logic [7:0]  r_ps;
    logic [7:0]  r_ps_cnt;

    // Using >= means a PS lowered mid-run ticks at once instead of wrapping.
    assign w_tick = (r_ps_cnt >= r_ps);

    // Prescale divider: restarts on every LOAD, advances only while counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ps     <= 8'd0;
            r_ps_cnt <= 8'd0;
        end else begin
            if (w_ctrl_wr) begin
                r_ps <= Din[15:8];
            end
            if (r_state == S_LOAD) begin
                r_ps_cnt <= 8'd0;
            end else if ((r_state == S_CNT) && r_en) begin
                r_ps_cnt <= w_tick ? 8'd0 : r_ps_cnt + 8'd1;
            end
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (r_en) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_CNT;
            S_CNT: begin
                if (!r_en) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tick && w_count_done) begin
                    w_state_nxt = S_INT;
                end
            end
            S_INT:   w_state_nxt = w_auto_reload ? S_LOAD : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // CTRL/PRESET registers; a CPU CTRL write beats the one-shot En clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en     <= 1'b0;
            r_mode   <= 2'd0;
            r_im     <= 1'b0;
            r_preset <= 32'd0;
        end else begin
            if (w_ctrl_wr) begin
                r_en   <= Din[0];
                r_mode <= Din[2:1];
                r_im   <= Din[3];
            end else if ((r_state == S_INT) && !w_auto_reload) begin
                r_en   <= 1'b0;
            end
            if (w_preset_wr) begin
                r_preset <= Din;
            end
        end
    end

    // Counter: loads PRESET in LOAD, decrements on ticks, saturates at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 32'd0;
        end else begin
            case (r_state)
                S_LOAD: r_count <= r_preset;
                S_CNT: begin
                    if (r_en && w_tick) begin
                        r_count <= w_count_done ? 32'd0 : r_count - 32'd1;
                    end
                end
                default: r_count <= r_count;
            endcase
        end
    end

    // Interrupt flag: set on INT entry, cleared by CPU writes or reload exit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_flag <= 1'b0;
        end else if (w_irq_set) begin
            r_irq_flag <= 1'b1;
        end else if (w_ctrl_wr || w_preset_wr ||
                     ((r_state == S_INT) && w_auto_reload)) begin
            r_irq_flag <= 1'b0;
        end
    end

    assign IRQ = r_irq_flag & r_im;

    // Combinational read mux.
    always_comb begin
        Dout = 32'd0;
        case (Addr)
`ifdef TC_PRESCALE_EN
            c_ADDR_CTRL:   Dout = {16'd0, r_ps, 4'd0, r_im, r_mode, r_en};
`else
            c_ADDR_CTRL:   Dout = {28'd0, r_im, r_mode, r_en};
`endif
            c_ADDR_PRESET: Dout = r_preset;
            c_ADDR_COUNT:  Dout = r_count;
            default:       Dout = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_tc_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tc_timer
//  Description : Self-checking bench for tc_timer: directed scenarios plus a
//                randomized register-access run against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tc_timer;

    logic        clk;
    logic        reset;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int n_vec = 0;
    int n_err = 0;

    tc_timer u_dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // ---------------- behavioural model ----------------
    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_CNT  = 2;
    localparam int PH_INT  = 3;

    int          m_phase;
    bit          m_en;
    int          m_mode;
    bit          m_im;
    int unsigned m_ps;
    int unsigned m_preset;
    int unsigned m_count;
    int unsigned m_cyc;     // enabled CNT cycles since the last LOAD
    bit          m_flag;

    task automatic model_reset();
        m_phase = PH_IDLE; m_en = 0; m_mode = 0; m_im = 0; m_ps = 0;
        m_preset = 0; m_count = 0; m_cyc = 0; m_flag = 0;
    endtask

    task automatic model_step(input bit rst, input bit we, input bit [1:0] addr,
                              input bit [31:0] din);
        int          nph;
        bit          nen, nim, nflag;
        int          nmode;
        int unsigned nps, npreset, ncount, ncyc;
        if (rst) begin
            model_reset();
            return;
        end
        nph = m_phase; nen = m_en; nim = m_im; nflag = m_flag; nmode = m_mode;
        nps = m_ps; npreset = m_preset; ncount = m_count; ncyc = m_cyc;
        case (m_phase)
            PH_IDLE: if (m_en) nph = PH_LOAD;
            PH_LOAD: begin ncount = m_preset; ncyc = 0; nph = PH_CNT; end
            PH_CNT: begin
                if (!m_en) nph = PH_IDLE;
                else begin
                    if ((m_cyc % (m_ps + 1)) == m_ps) begin
                        if (m_count > 1) ncount = m_count - 1;
                        else begin ncount = 0; nph = PH_INT; nflag = 1; end
                    end
                    ncyc = m_cyc + 1;
                end
            end
            default: begin
                if (m_mode == 1) begin nph = PH_LOAD; nflag = 0; end
                else begin nen = 0; nph = PH_IDLE; end
            end
        endcase
        if (we && addr == 2'd0) begin
            nen = din[0]; nmode = int'(din[2:1]); nim = din[3];
`ifdef TC_PRESCALE_EN
            nps = din[15:8];
`endif
        end
        if (we && addr == 2'd1) npreset = din;
        if (we && addr <= 2'd1 && !(m_phase == PH_CNT && nph == PH_INT)) nflag = 0;
        m_phase = nph; m_en = nen; m_im = nim; m_flag = nflag; m_mode = nmode;
        m_ps = nps; m_preset = npreset; m_count = ncount; m_cyc = ncyc;
    endtask

    function automatic logic [31:0] model_read(input int a);
        case (a)
            0:       return 32'(m_en) + 32'(m_mode) * 2 + 32'(m_im) * 8 + m_ps * 256;
            1:       return m_preset;
            2:       return m_count;
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // One clock: drive inputs, update the model, then check IRQ and all words.
    task automatic apply(input bit rst, input bit we, input bit [1:0] addr,
                         input bit [31:0] din);
        reset = rst; WE = we; Addr = addr; Din = din;
        @(posedge clk);
        model_step(rst, we, addr, din);
        #1;
        reset = 1'b0; WE = 1'b0;
        check_eq("irq", {31'd0, IRQ}, {31'd0, m_flag & m_im});
        for (int a = 0; a < 4; a++) begin
            Addr = 2'(a);
            #1;
            check_eq($sformatf("read%0d", a), Dout, model_read(a));
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) apply(0, 0, 2'd0, 32'd0);
    endtask

    task automatic peek(input logic [1:0] a, output logic [31:0] v);
        Addr = a;
        #1;
        v = Dout;
    endtask

    logic [31:0] v;
    bit          r_rst, r_we;
    bit [1:0]    r_addr;
    bit [31:0]   r_din;

    initial begin
        reset = 1'b1; WE = 1'b0; Addr = 2'd0; Din = 32'd0;
        model_reset();

        // Reset state
        apply(1, 0, 2'd0, 32'd0);
        peek(2'd0, v); check_eq("rst_ctrl", v, 32'd0);
        peek(2'd2, v); check_eq("rst_count", v, 32'd0);

        // One-shot run: PRESET=5, CTRL=0x9
        apply(0, 1, 2'd1, 32'd5);
        apply(0, 1, 2'd0, 32'h9);
        idle(1);
        for (int k = 0; k < 6; k++) begin
            idle(1);
            peek(2'd2, v); check_eq("oneshot_count", v, 32'(5 - k));
        end
        check_eq("oneshot_irq_entry", {31'd0, IRQ}, 32'd1);
        idle(3);
        peek(2'd0, v); check_eq("oneshot_en_clr", v, 32'h8);
        check_eq("oneshot_irq_held", {31'd0, IRQ}, 32'd1);
        apply(0, 1, 2'd0, 32'h8);
        check_eq("oneshot_irq_clr", {31'd0, IRQ}, 32'd0);

        // Auto-reload: PRESET=3, CTRL=0xB -> pulse every 5 cycles
        apply(1, 0, 2'd0, 32'd0);
        apply(0, 1, 2'd1, 32'd3);
        apply(0, 1, 2'd0, 32'hB);
        for (int i = 1; i <= 20; i++) begin
            idle(1);
            check_eq("reload_irq", {31'd0, IRQ}, (i % 5 == 0) ? 32'd1 : 32'd0);
        end

        // Masked flag, then CTRL write restarts with IM set
        apply(1, 0, 2'd0, 32'd0);
        apply(0, 1, 2'd1, 32'd4);
        apply(0, 1, 2'd0, 32'h1);
        idle(8);
        check_eq("masked_irq", {31'd0, IRQ}, 32'd0);
        apply(0, 1, 2'd0, 32'h9);
        check_eq("restart_irq_clr", {31'd0, IRQ}, 32'd0);
        for (int i = 1; i <= 6; i++) begin
            idle(1);
            check_eq("restart_irq", {31'd0, IRQ}, (i == 6) ? 32'd1 : 32'd0);
        end

        // Mid-count stop and PRESET change during CNT
        apply(1, 0, 2'd0, 32'd0);
        apply(0, 1, 2'd1, 32'd5);
        apply(0, 1, 2'd0, 32'h1);
        idle(3);
        apply(0, 1, 2'd1, 32'd7);
        peek(2'd2, v); check_eq("mid_preset_noeffect", v, 32'd3);
        apply(0, 1, 2'd0, 32'h0);
        idle(2);
        peek(2'd2, v); check_eq("mid_hold", v, 32'd2);
        apply(0, 1, 2'd0, 32'h1);
        idle(2);
        peek(2'd2, v); check_eq("mid_reload7", v, 32'd7);

        // Reset during INT overriding a CTRL write
        apply(1, 0, 2'd0, 32'd0);
        apply(0, 1, 2'd1, 32'd2);
        apply(0, 1, 2'd0, 32'h9);
        idle(4);
        check_eq("int_irq", {31'd0, IRQ}, 32'd1);
        apply(1, 1, 2'd0, 32'h9);
        check_eq("int_rst_irq", {31'd0, IRQ}, 32'd0);
        peek(2'd0, v); check_eq("int_rst_ctrl", v, 32'd0);
        idle(3);
        peek(2'd2, v); check_eq("int_rst_idle", v, 32'd0);

        // PRESET=0 behaves as 1; prescale field read-back
        apply(0, 1, 2'd0, 32'h0209);
        peek(2'd0, v);
`ifdef TC_PRESCALE_EN
        check_eq("ctrl_ps_read", v, 32'h209);
`else
        check_eq("ctrl_ps_read", v, 32'h9);
`endif
        apply(1, 0, 2'd0, 32'd0);
        apply(0, 1, 2'd0, 32'h9);
        idle(3);
        check_eq("preset0_irq", {31'd0, IRQ}, 32'd1);

        // Randomized register traffic
        apply(1, 0, 2'd0, 32'd0);
        for (int i = 0; i < 1500; i++) begin
            r_rst  = ($urandom_range(0, 99) == 0);
            r_we   = ($urandom_range(0, 5) == 0);
            r_addr = 2'($urandom_range(0, 3));
            r_din  = $urandom;
            if (r_addr == 2'd0) begin
`ifdef TC_PRESCALE_EN
                r_din[15:8] = 8'd0;
`endif
                r_din[0] = ($urandom_range(0, 3) != 0);
            end else if (r_addr == 2'd1) begin
                r_din = 32'($urandom_range(0, 12));
            end
            apply(r_rst, r_we, r_addr, r_din);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
